// File: rtl/ps2_key_event_decoder_pkg.sv
// Shared definitions for the PS/2 key event decoder: key indices, scan-code
// prefixes, event record layout and the scan-code-to-key lookup table.
package ps2_key_event_decoder_pkg;

    localparam int NUMBEROFKEYBOARDINPUTS = 29;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;

    localparam logic [4:0] KEY_TILDE = 5'd0,  KEY_1 = 5'd1,  KEY_2 = 5'd2,  KEY_3 = 5'd3;
    localparam logic [4:0] KEY_4     = 5'd4,  KEY_5 = 5'd5,  KEY_6 = 5'd6,  KEY_7 = 5'd7;
    localparam logic [4:0] KEY_8     = 5'd8,  KEY_9 = 5'd9,  KEY_0 = 5'd10, KEY_MINUS = 5'd11;
    localparam logic [4:0] KEY_EQUAL = 5'd12, KEY_BKSP = 5'd13, KEY_TAB = 5'd14;
    localparam logic [4:0] KEY_Q     = 5'd15, KEY_W = 5'd16, KEY_E = 5'd17, KEY_R = 5'd18;
    localparam logic [4:0] KEY_T     = 5'd19, KEY_Y = 5'd20, KEY_U = 5'd21, KEY_I = 5'd22;
    localparam logic [4:0] KEY_O     = 5'd23, KEY_P = 5'd24, KEY_LBRACKET = 5'd25;
    localparam logic [4:0] KEY_RBRACKET = 5'd26, KEY_BACKSLASH = 5'd27, KEY_SPACE = 5'd28;

    // One queued key event: which key, and whether it went down or up.
    typedef struct packed {
        logic [4:0] key;
        logic       press;
    } key_event_t;

    typedef struct packed {
        logic       hit;
        logic [4:0] idx;
    } key_lookup_t;

    // Set-2 scan code to key index; hit=0 for codes outside the mapped set.
    function automatic key_lookup_t scan_to_key(input logic [7:0] code);
        key_lookup_t r;
        r.hit = 1'b1;
        r.idx = KEY_TILDE;
        case (code)
            8'h0E: r.idx = KEY_TILDE;
            8'h16: r.idx = KEY_1;
            8'h1E: r.idx = KEY_2;
            8'h26: r.idx = KEY_3;
            8'h25: r.idx = KEY_4;
            8'h2E: r.idx = KEY_5;
            8'h36: r.idx = KEY_6;
            8'h3D: r.idx = KEY_7;
            8'h3E: r.idx = KEY_8;
            8'h46: r.idx = KEY_9;
            8'h45: r.idx = KEY_0;
            8'h4E: r.idx = KEY_MINUS;
            8'h55: r.idx = KEY_EQUAL;
            8'h66: r.idx = KEY_BKSP;
            8'h0D: r.idx = KEY_TAB;
            8'h15: r.idx = KEY_Q;
            8'h1D: r.idx = KEY_W;
            8'h24: r.idx = KEY_E;
            8'h2D: r.idx = KEY_R;
            8'h2C: r.idx = KEY_T;
            8'h35: r.idx = KEY_Y;
            8'h3C: r.idx = KEY_U;
            8'h43: r.idx = KEY_I;
            8'h44: r.idx = KEY_O;
            8'h4D: r.idx = KEY_P;
            8'h54: r.idx = KEY_LBRACKET;
            8'h5B: r.idx = KEY_RBRACKET;
            8'h5D: r.idx = KEY_BACKSLASH;
            8'h29: r.idx = KEY_SPACE;
            default: begin
                r.hit = 1'b0;
                r.idx = 5'd0;
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/key_event_fifo.sv
// Small synchronous FIFO for key events. The head entry is presented from a
// register so the consumer sees a stable value while it stalls.
module key_event_fifo #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             pop,
    output logic             empty,
    output logic [WIDTH-1:0] dout
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Extra MSB on each pointer tells full (MSBs differ) from empty (equal).
    logic [AW:0]      wr_ptr, rd_ptr, rd_next;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             push_ok, pop_ok;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_ok  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push_ok = push && (!full || pop_ok);
    assign rd_next = rd_ptr + (AW+1)'(pop_ok);

    // Storage write; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr[AW-1:0]] <= din;
    end

    // Pointer update; both wrap naturally modulo 2*DEPTH.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr + (AW+1)'(push_ok);
            rd_ptr <= rd_next;
        end
    end

    // Registered head: take the incoming word when it becomes the head,
    // otherwise the stored entry at the next read position.
    always_ff @(posedge clk) begin
        if (!resetn)
            dout <= '0;
        else if (rd_next == wr_ptr) begin
            if (push_ok)
                dout <= din;
        end else
            dout <= mem[rd_next[AW-1:0]];
    end

endmodule

// File: rtl/ps2_key_event_decoder.sv
// Decodes PS/2 set-2 scan-code bytes into per-key held levels and a queue of
// press/release events. Extended (E0-prefixed) keys are consumed but ignored.
module ps2_key_event_decoder
    import ps2_key_event_decoder_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int NUM_KEYS   = NUMBEROFKEYBOARDINPUTS
) (
    input  logic                CLOCK_50,
    input  logic                resetn,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic [NUM_KEYS-1:0] key_state,
    output logic                release_pulse,
    output logic                evt_valid,
    output logic [4:0]          evt_key,
    output logic                evt_press,
    input  logic                evt_ready,
    output logic                evt_overflow
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BRK     = 2'd1,
        EXT     = 2'd2,
        EXT_BRK = 2'd3
    } state_t;

    state_t      state, state_next;
    logic        make_byte, break_byte;
    key_lookup_t lookup;
    logic        key_hit, key_was_held;
    logic        evt_push, evt_pop, fifo_full, fifo_empty;
    key_event_t  evt_in, evt_head;

    assign lookup       = scan_to_key(rx_data);
    assign key_hit      = lookup.hit && (32'(lookup.idx) < NUM_KEYS);
    assign key_was_held = key_hit && key_state[lookup.idx];

    // An event is queued only on a real level change, so typematic repeats
    // and breaks of keys that were never seen down stay silent.
    assign evt_push     = key_hit && ((make_byte && !key_was_held) || (break_byte && key_was_held));
    assign evt_in.key   = lookup.idx;
    assign evt_in.press = make_byte;
    assign evt_pop      = evt_valid && evt_ready;
    assign evt_valid    = !fifo_empty;
    assign evt_key      = evt_head.key;
    assign evt_press    = evt_head.press;

    // Prefix state register.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Prefix tracking; only advances on received bytes.
    always_comb begin
        state_next = state;
        if (rx_valid) begin
            case (state)
                IDLE: begin
                    if (rx_data == SC_BREAK)
                        state_next = BRK;
                    else if (rx_data == SC_EXT)
                        state_next = EXT;
                end
                BRK:     state_next = IDLE;
                EXT:     state_next = (rx_data == SC_BREAK) ? EXT_BRK : IDLE;
                EXT_BRK: state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Classify the current byte as a make or break code for a standard key.
    always_comb begin
        release_pulse = (state == BRK);
        make_byte     = 1'b0;
        break_byte    = 1'b0;
        if (rx_valid) begin
            case (state)
                IDLE:    make_byte  = (rx_data != SC_BREAK) && (rx_data != SC_EXT);
                BRK:     break_byte = 1'b1;
                default: ;
            endcase
        end
    end

    // Held-key levels follow every mapped make/break, even if the event drops.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn)
            key_state <= '0;
        else if (key_hit && make_byte)
            key_state[lookup.idx] <= 1'b1;
        else if (key_hit && break_byte)
            key_state[lookup.idx] <= 1'b0;
    end

    // Sticky flag for an event lost to a full queue with no pop to make room.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn)
            evt_overflow <= 1'b0;
        else if (evt_push && fifo_full && !evt_pop)
            evt_overflow <= 1'b1;
    end

    key_event_fifo #(
        .WIDTH ($bits(key_event_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (CLOCK_50),
        .resetn (resetn),
        .push   (evt_push),
        .din    (evt_in),
        .full   (fifo_full),
        .pop    (evt_pop),
        .empty  (fifo_empty),
        .dout   (evt_head)
    );

endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// Bench for ps2_key_event_decoder: directed scan-code sequences, a
// key/queue-level reference model checked every cycle, plus literal checks.
module tb_ps2_key_event_decoder;

    localparam int DEPTH = 4;
    localparam int NK    = 29;

    logic          clk = 1'b0;
    logic          resetn;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic [NK-1:0] key_state;
    logic          release_pulse;
    logic          evt_valid;
    logic [4:0]    evt_key;
    logic          evt_press;
    logic          evt_ready;
    logic          evt_overflow;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    ps2_key_event_decoder #(.FIFO_DEPTH(DEPTH), .NUM_KEYS(NK)) dut (
        .CLOCK_50      (clk),
        .resetn        (resetn),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .key_state     (key_state),
        .release_pulse (release_pulse),
        .evt_valid     (evt_valid),
        .evt_key       (evt_key),
        .evt_press     (evt_press),
        .evt_ready     (evt_ready),
        .evt_overflow  (evt_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Scan codes listed in key-index order; position = key index.
    byte unsigned code_tab [NK] = '{8'h0E, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                   8'h3E, 8'h46, 8'h45, 8'h4E, 8'h55, 8'h66, 8'h0D, 8'h15,
                                   8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44,
                                   8'h4D, 8'h54, 8'h5B, 8'h5D, 8'h29};

    function automatic int find_key(input logic [7:0] c);
        for (int i = 0; i < NK; i++)
            if (code_tab[i] == c) return i;
        return -1;
    endfunction

    logic [NK-1:0] m_held;
    logic [5:0]    m_q [$];
    bit            m_ovf;
    int            m_pref;    // 0 none, 1 after F0, 2 after E0, 3 after E0 F0
    bit            m_have;
    logic [5:0]    m_ev;
    int            m_k;

    // Model update from the inputs seen at each rising edge.
    always @(posedge clk) begin
        if (!resetn) begin
            m_pref = 0;
            m_held = '0;
            m_q.delete();
            m_ovf  = 1'b0;
        end else begin
            m_have = 1'b0;
            if (rx_valid) begin
                case (m_pref)
                    0: begin
                        if (rx_data == 8'hF0) m_pref = 1;
                        else if (rx_data == 8'hE0) m_pref = 2;
                        else begin
                            m_k = find_key(rx_data);
                            if (m_k >= 0) begin
                                if (!m_held[m_k]) begin m_have = 1'b1; m_ev = {5'(m_k), 1'b1}; end
                                m_held[m_k] = 1'b1;
                            end
                        end
                    end
                    1: begin
                        m_pref = 0;
                        m_k = find_key(rx_data);
                        if (m_k >= 0) begin
                            if (m_held[m_k]) begin m_have = 1'b1; m_ev = {5'(m_k), 1'b0}; end
                            m_held[m_k] = 1'b0;
                        end
                    end
                    2: m_pref = (rx_data == 8'hF0) ? 3 : 0;
                    default: m_pref = 0;
                endcase
            end
            if (m_q.size() > 0 && evt_ready) void'(m_q.pop_front());
            if (m_have) begin
                if (m_q.size() < DEPTH) m_q.push_back(m_ev);
                else m_ovf = 1'b1;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("key_state", 32'(key_state), 32'(m_held));
            check("release_pulse", 32'(release_pulse), 32'(m_pref == 1));
            check("evt_valid", 32'(evt_valid), 32'(m_q.size() > 0));
            check("evt_overflow", 32'(evt_overflow), 32'(m_ovf));
            if (m_q.size() > 0) begin
                check("evt_key", 32'(evt_key), 32'(m_q[0][5:1]));
                check("evt_press", 32'(evt_press), 32'(m_q[0][0]));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_with_pop(input logic [7:0] b);
        @(negedge clk);
        rx_valid  = 1'b1;
        rx_data   = b;
        evt_ready = 1'b1;
        @(negedge clk);
        rx_valid  = 1'b0;
        evt_ready = 1'b0;
    endtask

    task automatic drain();
        @(negedge clk);
        evt_ready = 1'b1;
        repeat (DEPTH + 2) @(negedge clk);
        evt_ready = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    logic [4:0] exp_k [4] = '{5'd1, 5'd1, 5'd2, 5'd2};
    logic       exp_p [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        // Reset with a byte strobing; it must be ignored.
        resetn    = 1'b0;
        rx_valid  = 1'b1;
        rx_data   = 8'h15;
        evt_ready = 1'b0;
        repeat (3) @(negedge clk);
        rx_valid = 1'b0;
        resetn   = 1'b1;
        cmp_en   = 1'b1;
        #1;
        check("rst_key_state", 32'(key_state), 32'h0);
        check("rst_evt_valid", 32'(evt_valid), 32'h0);
        check("rst_release", 32'(release_pulse), 32'h0);
        check("rst_overflow", 32'(evt_overflow), 32'h0);
        check("rst_evt_key", 32'(evt_key), 32'h0);
        check("rst_evt_press", 32'(evt_press), 32'h0);

        // Make and break of Q.
        send(8'h15);
        #1;
        check("q_make_state", 32'(key_state), 32'h0000_8000);
        check("q_make_valid", 32'(evt_valid), 32'h1);
        check("q_make_key", 32'(evt_key), 32'd15);
        check("q_make_press", 32'(evt_press), 32'h1);
        send(8'hF0);
        #1;
        check("f0_release_hi", 32'(release_pulse), 32'h1);
        send(8'h15);
        #1;
        check("q_brk_release_lo", 32'(release_pulse), 32'h0);
        check("q_brk_state", 32'(key_state), 32'h0);
        drain();
        #1;
        check("drained_valid", 32'(evt_valid), 32'h0);

        // Typematic repeats give one event.
        send(8'h15); send(8'h15); send(8'h15);
        #1;
        check("rep_state", 32'(key_state), 32'h0000_8000);
        check("rep_head_key", 32'(evt_key), 32'd15);
        @(negedge clk); evt_ready = 1'b1;
        @(negedge clk); evt_ready = 1'b0;
        #1;
        check("rep_single_event", 32'(evt_valid), 32'h0);
        send(8'hF0); send(8'h15);
        drain();

        // Extended sequences are ignored and return to IDLE.
        send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
        #1;
        check("ext_state", 32'(key_state), 32'h0);
        check("ext_no_event", 32'(evt_valid), 32'h0);
        send(8'h16);
        #1;
        check("ext_then_idle_key", 32'(evt_key), 32'd1);
        check("ext_then_idle_press", 32'(evt_press), 32'h1);
        send(8'hF0); send(8'h16);
        drain();

        // Unmapped code.
        send(8'h1C);
        #1;
        check("unmapped_state", 32'(key_state), 32'h0);
        check("unmapped_event", 32'(evt_valid), 32'h0);

        // Overflow: 10 events into a 4-deep queue.
        send(8'h16); send(8'hF0); send(8'h16);
        send(8'h1E); send(8'hF0); send(8'h1E);
        send(8'h26); send(8'hF0); send(8'h26);
        send(8'h25); send(8'hF0); send(8'h25);
        send(8'h2E); send(8'hF0); send(8'h2E);
        #1;
        check("ovf_flag", 32'(evt_overflow), 32'h1);
        for (int i = 0; i < 4; i++) begin
            check("ovf_order_key", 32'(evt_key), 32'(exp_k[i]));
            check("ovf_order_press", 32'(evt_press), 32'(exp_p[i]));
            @(negedge clk); evt_ready = 1'b1;
            @(negedge clk); evt_ready = 1'b0;
            #1;
        end
        check("ovf_drained", 32'(evt_valid), 32'h0);
        check("ovf_sticky", 32'(evt_overflow), 32'h1);
        pulse_reset();
        #1;
        check("ovf_cleared", 32'(evt_overflow), 32'h0);

        // Full with simultaneous pop accepts the push.
        send(8'h16); send(8'hF0); send(8'h16);
        send(8'h1E); send(8'hF0); send(8'h1E);
        send_with_pop(8'h26);
        #1;
        check("full_pop_no_ovf", 32'(evt_overflow), 32'h0);
        check("full_pop_head_key", 32'(evt_key), 32'd1);
        check("full_pop_head_press", 32'(evt_press), 32'h0);
        drain();

        // Reset after F0 discards the partial break.
        send(8'hF0);
        pulse_reset();
        #1;
        check("rst_mid_release", 32'(release_pulse), 32'h0);
        send(8'h29);
        #1;
        check("space_state", 32'(key_state), 32'h1000_0000);
        check("space_key", 32'(evt_key), 32'd28);
        check("space_press", 32'(evt_press), 32'h1);
        check("space_release", 32'(release_pulse), 32'h0);
        drain();

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
